// File: rtl/neuron_pkg.sv
// Shared types and default sizing for the neuron MAC sequencer.
package neuron_pkg;

  localparam int unsigned DefaultDataW  = 8;
  localparam int unsigned DefaultAddrW  = 8;
  localparam int unsigned DefaultAccW   = 24;
  localparam int unsigned WeightBaseDef = 128;

  typedef enum logic [2:0] {
    StIdle,
    StFetchX,
    StFetchW,
    StMac,
    StOut
  } state_e;

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Control, RAM read and result handshake bundle of the neuron MAC sequencer.
interface neuron_mac_seq_if
  import neuron_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
);
  logic              start;
  logic [ADDR_W-1:0] num_inputs;
  logic              busy;
  logic [ADDR_W-1:0] read_address;
  logic              oe;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] result;
  logic              out_valid;
  logic              out_ready;

  // master: host/RAM side, slave: the neuron.
  modport master (
    output start, num_inputs, read_data, out_ready,
    input  busy, read_address, oe, result, out_valid
  );

  modport slave (
    input  start, num_inputs, read_data, out_ready,
    output busy, read_address, oe, result, out_valid
  );
endinterface

// File: rtl/neuron_sat_act.sv
// Fixed-point rescale, signed saturation and optional ReLU (macro NEURON_RELU_EN).
module neuron_sat_act #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned FRAC_BITS = 4
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] MaxVal = $signed(ACC_W'(2 ** (DATA_W - 1) - 1));
  localparam logic signed [ACC_W-1:0] MinVal = ~MaxVal;

  logic signed [ACC_W-1:0] shifted;
  logic        [DATA_W-1:0] sat;

  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > MaxVal) begin
      sat = MaxVal[DATA_W-1:0];
    end else if (shifted < MinVal) begin
      sat = MinVal[DATA_W-1:0];
    end else begin
      sat = shifted[DATA_W-1:0];
    end
`ifdef NEURON_RELU_EN
    result = sat[DATA_W-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential dot-product neuron: x[i] at RAM[i], w[i] at RAM[WEIGHT_BASE+i], one term per
// three cycles. Output activation is ReLU when NEURON_RELU_EN is defined.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned ACC_W       = DefaultAccW,
  parameter int unsigned WEIGHT_BASE = WeightBaseDef,
  parameter int unsigned FRAC_BITS   = 4
) (
  input logic             clk,
  input logic             rst,
  neuron_mac_seq_if.slave bus
);

  localparam int unsigned ProdW = 2 * DATA_W;

  state_e                   state_q;
  logic [ADDR_W-1:0]        n_q;
  logic [ADDR_W-1:0]        idx_q;
  logic [ADDR_W-1:0]        addr_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     busy_q;
  logic                     oe_q;
  logic                     valid_q;

  logic signed [DATA_W-1:0] w_cur;
  logic signed [ProdW-1:0]  prod;
  logic [ADDR_W-1:0]        idx_next;
  logic [ADDR_W-1:0]        weight_addr;

  // The weight arrives on read_data during MAC and is consumed directly.
  assign w_cur       = $signed(bus.read_data);
  assign prod        = x_q * w_cur;
  assign idx_next    = idx_q + ADDR_W'(1);
  assign weight_addr = idx_q + ADDR_W'(WEIGHT_BASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            n_q    <= bus.num_inputs;
            idx_q  <= '0;
            acc_q  <= '0;
            addr_q <= '0;
            busy_q <= 1'b1;
            if (bus.num_inputs == '0) begin
              state_q <= StOut;
              valid_q <= 1'b1;
            end else begin
              state_q <= StFetchX;
              oe_q    <= 1'b1;
            end
          end
        end
        StFetchX: begin
          state_q <= StFetchW;
          addr_q  <= weight_addr;
          oe_q    <= 1'b1;
        end
        StFetchW: begin
          state_q <= StMac;
          x_q     <= $signed(bus.read_data);
          oe_q    <= 1'b0;
        end
        StMac: begin
          acc_q <= acc_q + ACC_W'(prod);
          idx_q <= idx_next;
          if (idx_next == n_q) begin
            state_q <= StOut;
            valid_q <= 1'b1;
          end else begin
            state_q <= StFetchX;
            addr_q  <= idx_next;
            oe_q    <= 1'b1;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  neuron_sat_act #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_act (
    .acc    (acc_q),
    .result (bus.result)
  );

  assign bus.busy         = busy_q;
  assign bus.oe           = oe_q;
  assign bus.read_address = addr_q;
  assign bus.out_valid    = valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized and directed bench for neuron_mac_seq against a dot-product reference model.
module tb_neuron_mac_seq;
  localparam int unsigned WB = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_seq_if bus ();

  neuron_mac_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] ram_q = '0;
  assign bus.read_data = ram_q;

  always @(posedge clk) if (bus.oe) ram_q <= mem[bus.read_address];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int oe_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Dot product of the first n RAM terms, rescaled, clamped and optionally rectified.
  function automatic logic [7:0] ref_result(input int n);
    longint acc = 0;
    longint sh;
    for (int i = 0; i < n; i++) begin
      int xa = $signed(mem[i]);
      int wb = $signed(mem[(WB + i) % 256]);
      acc += longint'(xa * wb);
    end
    sh = acc >>> 4;
    if (sh > 127) sh = 127;
    if (sh < -128) sh = -128;
`ifdef NEURON_RELU_EN
    if (sh < 0) sh = 0;
`endif
    return sh[7:0];
  endfunction

  // Model timeline: m_k counts edges since the start edge; 3 cycles per term, then OUT.
  bit         m_active = 1'b0;
  bit         m_out = 1'b0;
  int         m_k = 0;
  int         m_n = 0;
  logic [7:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_out    = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k == 3 * m_n) begin
        m_active = 1'b0;
        m_out    = 1'b1;
      end
    end else if (m_out) begin
      if (bus.out_ready) m_out = 1'b0;
    end else if (bus.start) begin
      m_n   = int'(bus.num_inputs);
      m_k   = 0;
      m_res = ref_result(m_n);
      if (m_n == 0) m_out = 1'b1;
      else m_active = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.oe) oe_cnt++;
    if (chk_en) begin
      check("busy", bus.busy, m_active || m_out);
      check("out_valid", bus.out_valid, m_out);
      if (m_active) begin
        check("oe", bus.oe, (m_k % 3) != 2);
        if ((m_k % 3) == 0) check("addr_x", bus.read_address, m_k / 3);
        if ((m_k % 3) == 1) check("addr_w", bus.read_address, (WB + m_k / 3) % 256);
      end else begin
        check("oe_idle", bus.oe, 0);
      end
      if (m_out) check("result", bus.result, m_res);
    end
  end

  // One operation from an idle DUT; holds out_ready low for 'hold' cycles once valid.
  task automatic run_op(input int n, input int hold, input logic [7:0] exp_res,
                        input string tag);
    int lat = 0;
    @(negedge clk);
    oe_cnt         = 0;
    bus.start      = 1'b1;
    bus.num_inputs = 8'(n);
    @(posedge clk);
    #1 bus.start = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (lat > 3 * n + 20) begin
        check({tag, "_timeout"}, 0, 1);
        $display("FAIL %s: out_valid never rose", tag);
        $fatal(1, "timeout");
      end
    end
    check({tag, "_latency"}, lat, 3 * n + 1);
    check({tag, "_result"}, bus.result, exp_res);
    for (int i = 0; i < hold; i++) @(negedge clk);
    check({tag, "_held_valid"}, bus.out_valid, 1);
    check({tag, "_held_result"}, bus.result, exp_res);
    check({tag, "_oe_count"}, oe_cnt, 2 * n);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_exit"}, bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic set_basic();
    mem[0]   = 8'd3;
    mem[1]   = 8'd4;
    mem[128] = 8'd16;
    mem[129] = 8'd32;
  endtask

  initial begin
    logic [7:0] exp_neg;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_inputs = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_oe", bus.oe, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_addr", bus.read_address, 0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // 3*16 + 4*32 = 176, >>>4 = 11.
    set_basic();
    run_op(2, 0, 8'd11, "basic");
    check("model_basic", ref_result(2), 8'd11);

    mem[0] = 8'd127; mem[128] = 8'd127;
    run_op(1, 2, 8'd127, "sat_pos");

`ifdef NEURON_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'hFE;
`endif
    mem[0] = 8'hFE; mem[128] = 8'd16;
    run_op(1, 0, exp_neg, "neg");
    check("model_neg", ref_result(1), exp_neg);

    run_op(0, 0, 8'd0, "n_zero");

    set_basic();
    run_op(2, 10, 8'd11, "stall");

    // Reset while fetching the first weight, then a clean rerun.
    mem[2] = 8'd5; mem[130] = 8'd7;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_inputs = 8'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_oe", bus.oe, 0);
    check("midrst_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2, 1, 8'd11, "after_rst");

    for (int t = 0; t < 25; t++) begin
      int n;
      n = (t == 24) ? 200 : int'($urandom_range(0, 12));
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_op(n, int'($urandom_range(0, 4)), ref_result(n), "rand");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM data and result width.
REQ-002 SHALL have parameter ADDR_W, default 8, RAM address and term-count width.
REQ-003 SHALL have parameter ACC_W, default 24, signed accumulator width.
REQ-004 SHALL have parameter WEIGHT_BASE, default 128, RAM address of weight w[0].
REQ-005 SHALL have parameter FRAC_BITS, default 4, arithmetic right shift applied to the accumulator before saturation.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port start  input  1  request one dot-product; sampled only in IDLE.
REQ-009 SHALL have port num_inputs  input  ADDR_W  term count N; latched when start is accepted.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port read_address  output  ADDR_W  RAM read address.
REQ-012 SHALL have port oe  output  1  RAM read enable.
REQ-013 SHALL have port read_data  input  DATA_W  RAM read data, valid one clk after the address and oe are presented.
REQ-014 SHALL have port result  output  DATA_W  signed neuron output.
REQ-015 SHALL have port out_valid  output  1  result valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH_X, FETCH_W, MAC and OUT.
REQ-018 SHALL move IDLE->FETCH_X on start=1 with N>0, IDLE->OUT with the accumulator at 0 on start=1 with N=0, and otherwise stay in IDLE.
REQ-019 SHALL, in FETCH_X, drive read_address=i and oe=1 (i is the term index, starting at 0), then go to FETCH_W.
REQ-020 SHALL, in FETCH_W, drive read_address=WEIGHT_BASE+i (modulo 2^ADDR_W) and oe=1, and latch read_data as x[i].
REQ-021 SHALL, in MAC, hold oe=0, latch read_data as w[i], perform acc += sign_extend(x[i]*w[i]) using signed DATA_W x DATA_W -> 2*DATA_W multiplication, and increment i.
REQ-022 SHALL, from MAC, go to OUT if i+1==N, else to FETCH_X.
REQ-023 SHALL hold out_valid=1 and a stable result in OUT, and move OUT->IDLE on the edge where out_ready=1.
REQ-024 SHALL keep out_valid asserted indefinitely while out_ready=0.
REQ-025 SHALL assert out_valid exactly 3N+1 cycles after the edge on which start is sampled.
REQ-026 SHALL ignore start while busy=1; a start held high after return to IDLE begins a new operation.
REQ-027 SHALL compute result = clamp(acc >>> FRAC_BITS, -2^(DATA_W-1), 2^(DATA_W-1)-1).
REQ-028 SHALL have an ACC_W wide enough that N <= 255 full-scale products cannot overflow; no wrap handling is needed.
REQ-029 SHALL keep oe=0 in IDLE and OUT; read_address is don't-care whenever oe=0.

Reset
REQ-030 SHALL, on rst=1 at any clk edge (including mid-operation), enter IDLE and clear acc, i, x and w to 0.
REQ-031 SHALL, under reset, drive busy=0, oe=0, out_valid=0, result=0 and read_address=0.
REQ-032 SHALL give rst priority over start.

Configuration
REQ-033 SHALL, when the macro NEURON_RELU_EN is defined, apply ReLU after saturation so negative results become 0.
REQ-034 SHALL, when NEURON_RELU_EN is undefined, output the saturated signed value unchanged.

Structure
REQ-035 SHALL take the FSM state encoding, default DATA_W, ADDR_W and ACC_W, and WEIGHT_BASE from the shared package neuron_pkg.
REQ-036 SHALL put shift, saturation and the optional ReLU in one combinational sub-module, neuron_sat_act, instantiated once.

Verification
REQ-037 SHALL cover: N=2, RAM[0]=3, RAM[1]=4, RAM[128]=16, RAM[129]=32 -> result=11 (176>>>4), out_valid 7 cycles after start.
REQ-038 SHALL cover: N=1, x=127, w=127 -> result=127 (saturated, 16129>>>4=1008).
REQ-039 SHALL cover: N=1, x=0xFE, w=16 -> result=0xFE without NEURON_RELU_EN and 0x00 with it.
REQ-040 SHALL cover: N=0 -> out_valid=1 one cycle after start with result=0, and zero cycles with oe=1.
REQ-041 SHALL cover: out_ready=0 for 10 cycles in OUT -> out_valid and result stable, then exit the cycle after out_ready=1.
REQ-042 SHALL cover: rst=1 during FETCH_W of N=3 -> next cycle IDLE with busy=0 and oe=0; a following start with N=2 reproduces the REQ-037 result.
